// File: rtl/delay_buffer_pkg.sv
// Shared types and helpers for the runtime-programmable 2D delay buffer.
package delay_buffer_pkg;

  // FILL: ring not yet primed for the current delay; RUN: outputs live.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Limit a requested delay to the ring depth.
  function automatic int clamp_delay(input int sel, input int max_delay);
    return (sel > max_delay) ? max_delay : sel;
  endfunction

endpackage

// File: rtl/delay_buffer_ring_2d.sv
// delay_ring_2d: ring memory of MAX_DELAY entries {valid, data array},
// write pointer, and the read-index arithmetic for a runtime delay.
module delay_ring_2d #(
  parameter int NUM_FEATURES = 4,
  parameter int N            = 4,
  parameter int PRECISION    = 4,
  parameter int MAX_DELAY    = 8,
  parameter int DW           = $clog2(MAX_DELAY + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         ce,
  input  logic                                         ivalid,
  input  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] idata,
  input  logic [DW-1:0]                                cur_delay,
  output logic                                         rd_valid,
  output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] rd_data
);

  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] mem_data [MAX_DELAY];
  logic [MAX_DELAY-1:0]                          mem_valid;
  logic [AW-1:0]                                 wptr;
  logic [DW:0]                                   rd_sum;
  logic [AW-1:0]                                 rd_idx;

  // Pointer and valid bits reset; a slot whose valid bit is cleared is never trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      mem_valid <= '0;
    end else if (ce) begin
      mem_valid[wptr] <= ivalid;
      wptr            <= (wptr == AW'(MAX_DELAY - 1)) ? '0 : wptr + AW'(1);
    end
  end

  // Data payload needs no reset; it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (ce) begin
      mem_data[wptr] <= idata;
    end
  end

  // Read slot (wptr - cur_delay) mod MAX_DELAY; cur_delay == MAX_DELAY lands on wptr,
  // the oldest entry, which is still intact until the next ce edge.
  always_comb begin
    rd_sum = {1'b0, DW'(wptr)} + (DW+1)'(MAX_DELAY) - {1'b0, cur_delay};
    if (rd_sum >= (DW+1)'(MAX_DELAY)) begin
      rd_sum = rd_sum - (DW+1)'(MAX_DELAY);
    end
    rd_idx   = AW'(rd_sum);
    rd_data  = mem_data[rd_idx];
    rd_valid = mem_valid[rd_idx];
  end

endmodule

// File: rtl/delay_buffer_2d_var.sv
// delay_buffer_2d_var: runtime-programmable delay line for a
// NUM_FEATURES x N array of PRECISION-bit words, with ce stall and valid
// tracking. Outputs are held at zero while the line refills after reset or
// a delay reload.
// Optional build macro DELAY_BUFFER_OUTPUT_REG_EN registers odata, ovalid
// and filling (one extra clk of latency, updated every clock).
//
// Stream semantics: there is no backpressure. Every clock with ce=1 accepts
// the {ivalid, idata} presented and advances the line by one; ivalid only
// marks whether that sample is meaningful and is delayed with it.
module delay_buffer_2d_var
  import delay_buffer_pkg::*;
#(
  parameter int NUM_FEATURES  = 4,
  parameter int N             = 4,
  parameter int PRECISION     = 4,
  parameter int MAX_DELAY     = 8,
  parameter int DEFAULT_DELAY = 2,
  localparam int DW           = $clog2(MAX_DELAY + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         ce,
  input  logic                                         delay_ld,
  input  logic [DW-1:0]                                delay_sel,
  input  logic                                         ivalid,
  input  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] idata,
  output logic                                         ovalid,
  output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] odata,
  output logic                                         filling
);

  localparam state_t RESET_STATE = (DEFAULT_DELAY == 0) ? RUN : FILL;

  state_t                                        state, state_n;
  logic [DW-1:0]                                 cur_delay, cur_delay_n;
  logic [DW-1:0]                                 fill_cnt, fill_cnt_n;
  logic [DW-1:0]                                 sel_clamped;
  logic                                          rd_valid;
  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] rd_data;
  logic                                          out_valid;
  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] out_data;
  logic                                          out_filling;

  delay_ring_2d #(
    .NUM_FEATURES(NUM_FEATURES),
    .N           (N),
    .PRECISION   (PRECISION),
    .MAX_DELAY   (MAX_DELAY),
    .DW          (DW)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .ivalid   (ivalid),
    .idata    (idata),
    .cur_delay(cur_delay),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  assign sel_clamped = DW'(clamp_delay(int'(delay_sel), MAX_DELAY));

  // State, active delay and fill progress registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_STATE;
      cur_delay <= DW'(DEFAULT_DELAY);
      fill_cnt  <= '0;
    end else begin
      state     <= state_n;
      cur_delay <= cur_delay_n;
      fill_cnt  <= fill_cnt_n;
    end
  end

  // Next state: a load restarts the fill regardless of ce and wins over
  // the FILL->RUN step; otherwise FILL counts ce advances up to cur_delay.
  always_comb begin
    state_n     = state;
    cur_delay_n = cur_delay;
    fill_cnt_n  = fill_cnt;
    if (delay_ld) begin
      cur_delay_n = sel_clamped;
      fill_cnt_n  = '0;
      state_n     = (sel_clamped == '0) ? RUN : FILL;
    end else if (state == FILL && ce) begin
      fill_cnt_n = fill_cnt + DW'(1);
      if (fill_cnt + DW'(1) == cur_delay) begin
        state_n = RUN;
      end
    end
  end

  // Output mux: bypass at delay 0, ring read in RUN, zeros while filling.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    if (cur_delay == '0) begin
      out_data  = idata;
      out_valid = ivalid & (state == RUN);
    end else if (state == RUN) begin
      out_data  = rd_data;
      out_valid = rd_valid;
    end
  end

  assign out_filling = (state == FILL);

`ifdef DELAY_BUFFER_OUTPUT_REG_EN
  // Output register, free-running on clk so it never freezes with ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odata   <= '0;
      ovalid  <= 1'b0;
      filling <= (RESET_STATE == FILL);
    end else begin
      odata   <= out_data;
      ovalid  <= out_valid;
      filling <= out_filling;
    end
  end
`else
  assign odata   = out_data;
  assign ovalid  = out_valid;
  assign filling = out_filling;
`endif

endmodule

// File: tb/tb_delay_buffer_2d_var.sv
// Directed bench for delay_buffer_2d_var at default parameters
// (4x4x4-bit array, MAX_DELAY=8, DEFAULT_DELAY=2), combinational outputs.
module tb_delay_buffer_2d_var;

  typedef logic [3:0][3:0][3:0] arr_t;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       delay_ld;
  logic [3:0] delay_sel;
  logic       ivalid;
  arr_t       idata;
  logic       ovalid;
  arr_t       odata;
  logic       filling;

  int checks = 0;
  int errors = 0;
  int seq    = 1;
  bit sent_valid [0:1023];

  delay_buffer_2d_var dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .delay_ld (delay_ld),
    .delay_sel(delay_sel),
    .ivalid   (ivalid),
    .idata    (idata),
    .ovalid   (ovalid),
    .odata    (odata),
    .filling  (filling)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample row pattern: element [f][n] = a + f + n (mod 16).
  function automatic arr_t mk(input int a);
    arr_t r;
    for (int f = 0; f < 4; f++)
      for (int n = 0; n < 4; n++)
        r[f][n] = 4'(a + f + n);
    return r;
  endfunction

  // Drive one cycle of inputs; ce=0 cycles carry a junk row that must never appear.
  task automatic present(input bit ce_i, input bit v_i, input bit ld_i, input logic [3:0] sel_i);
    ce        = ce_i;
    ivalid    = v_i;
    delay_ld  = ld_i;
    delay_sel = sel_i;
    idata     = ce_i ? mk(seq) : mk(200);
    if (ce_i) sent_valid[seq] = v_i;
  endtask

  // Move to just after the next rising edge.
  task automatic advance();
    @(posedge clk);
    #1;
    if (ce) seq++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b0; delay_ld = 1'b0; delay_sel = '0; ivalid = 1'b0; idata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (filling !== 1'b1) begin errors++; $display("FAIL reset_filling got=%b exp=1", filling); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b exp=0", ovalid); end
    checks++; if (odata !== '0) begin errors++; $display("FAIL reset_odata got=%h exp=0", odata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    seq = 1;
  endtask

  task automatic test_fill_default();
    for (int i = 0; i < 6; i++) begin
      present(1, 1, 0, 0);
      #1;
      if (i < 2) begin
        checks++;
        if (filling !== 1'b1 || ovalid !== 1'b0 || odata !== '0) begin
          errors++; $display("FAIL fill_default_fill i=%0d got f=%b v=%b d=%h", i, filling, ovalid, odata);
        end
      end else begin
        checks++;
        if (filling !== 1'b0 || ovalid !== 1'b1 || odata !== mk(seq - 2)) begin
          errors++; $display("FAIL fill_default_run i=%0d got f=%b v=%b d=%h exp d=%h", i, filling, ovalid, odata, mk(seq - 2));
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 7; i++) begin
      present(i >= 3, 1, 0, 0);
      #1;
      checks++;
      if (ovalid !== 1'b1 || odata !== mk(seq - 2) || filling !== 1'b0) begin
        errors++; $display("FAIL stall i=%0d got v=%b d=%h exp d=%h", i, ovalid, odata, mk(seq - 2));
      end
      advance();
    end
  endtask

  task automatic test_max_delay(input logic [3:0] sel, input int old_d);
    present(1, 1, 1, sel);
    #1;
    checks++;
    if (ovalid !== sent_valid[seq - old_d] || odata !== mk(seq - old_d)) begin
      errors++; $display("FAIL max_load_cycle sel=%0d got v=%b d=%h exp d=%h", sel, ovalid, odata, mk(seq - old_d));
    end
    advance();
    for (int i = 0; i < 8; i++) begin
      present(1, 1, 0, 0);
      #1;
      checks++;
      if (filling !== 1'b1 || ovalid !== 1'b0 || odata !== '0) begin
        errors++; $display("FAIL max_fill sel=%0d i=%0d got f=%b v=%b d=%h", sel, i, filling, ovalid, odata);
      end
      advance();
    end
    for (int i = 0; i < 10; i++) begin
      present(1, 1, 0, 0);
      #1;
      checks++;
      if (filling !== 1'b0 || ovalid !== 1'b1 || odata !== mk(seq - 8)) begin
        errors++; $display("FAIL max_run sel=%0d i=%0d got f=%b v=%b d=%h exp d=%h", sel, i, filling, ovalid, odata, mk(seq - 8));
      end
      advance();
    end
  endtask

  task automatic test_valid_gaps();
    present(1, (seq % 3) != 0, 1, 4'd3);
    #1;
    checks++;
    if (ovalid !== sent_valid[seq - 8] || odata !== mk(seq - 8)) begin
      errors++; $display("FAIL gaps_load_cycle got v=%b d=%h exp d=%h", ovalid, odata, mk(seq - 8));
    end
    advance();
    for (int i = 0; i < 13; i++) begin
      present(1, (seq % 3) != 0, 0, 0);
      #1;
      if (i < 3) begin
        checks++;
        if (filling !== 1'b1 || ovalid !== 1'b0) begin
          errors++; $display("FAIL gaps_fill i=%0d got f=%b v=%b", i, filling, ovalid);
        end
      end else begin
        checks++;
        if (ovalid !== sent_valid[seq - 3] || odata !== mk(seq - 3)) begin
          errors++; $display("FAIL gaps_run i=%0d got v=%b d=%h exp v=%b d=%h", i, ovalid, odata, sent_valid[seq - 3], mk(seq - 3));
        end
      end
      advance();
    end
  endtask

  task automatic test_bypass();
    arr_t exp_d;
    present(1, 1, 1, 4'd0);
    #1;
    checks++;
    if (ovalid !== sent_valid[seq - 3] || odata !== mk(seq - 3)) begin
      errors++; $display("FAIL bypass_load_cycle got v=%b d=%h exp d=%h", ovalid, odata, mk(seq - 3));
    end
    advance();
    for (int i = 0; i < 6; i++) begin
      present(i != 2, i[0], 0, 0);
      exp_d = (i != 2) ? mk(seq) : mk(200);
      #1;
      checks++;
      if (filling !== 1'b0 || ovalid !== i[0] || odata !== exp_d) begin
        errors++; $display("FAIL bypass i=%0d got f=%b v=%b d=%h exp v=%b d=%h", i, filling, ovalid, odata, i[0], exp_d);
      end
      advance();
    end
    present(0, 1, 0, 0);
    idata = mk(77);
    #1;
    checks++;
    if (odata !== mk(77) || ovalid !== 1'b1) begin
      errors++; $display("FAIL bypass_comb got v=%b d=%h exp d=%h", ovalid, odata, mk(77));
    end
    ivalid = 1'b0;
    #1;
    checks++;
    if (ovalid !== 1'b0) begin
      errors++; $display("FAIL bypass_comb_valid got=%b exp=0", ovalid);
    end
    advance();
  endtask

  task automatic test_fill_restart();
    bit ce_pat [6] = '{1, 1, 0, 1, 1, 1};
    present(1, 1, 1, 4'd3);
    #1;
    checks++;
    if (ovalid !== 1'b1 || odata !== mk(seq)) begin
      errors++; $display("FAIL restart_load3_cycle got v=%b d=%h exp d=%h", ovalid, odata, mk(seq));
    end
    advance();
    present(1, 1, 1, 4'd5);
    #1;
    checks++;
    if (filling !== 1'b1 || ovalid !== 1'b0) begin
      errors++; $display("FAIL restart_load5_cycle got f=%b v=%b", filling, ovalid);
    end
    advance();
    for (int i = 0; i < 6; i++) begin
      present(ce_pat[i], 1, 0, 0);
      #1;
      checks++;
      if (filling !== 1'b1 || ovalid !== 1'b0 || odata !== '0) begin
        errors++; $display("FAIL restart_fill i=%0d got f=%b v=%b d=%h", i, filling, ovalid, odata);
      end
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      present(1, 1, 0, 0);
      #1;
      checks++;
      if (filling !== 1'b0 || ovalid !== 1'b1 || odata !== mk(seq - 5)) begin
        errors++; $display("FAIL restart_run i=%0d got f=%b v=%b d=%h exp d=%h", i, filling, ovalid, odata, mk(seq - 5));
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    present(1, 1, 0, 0);
    #1;
    checks++;
    if (ovalid !== 1'b1 || odata !== mk(seq - 5)) begin
      errors++; $display("FAIL rstmid_before got v=%b d=%h exp d=%h", ovalid, odata, mk(seq - 5));
    end
    #1;
    rst_n = 1'b0;
    ce    = 1'b0;
    #1;
    checks++;
    if (ovalid !== 1'b0 || odata !== '0 || filling !== 1'b1) begin
      errors++; $display("FAIL rstmid_async got f=%b v=%b d=%h", filling, ovalid, odata);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    seq = 1;
    for (int i = 0; i < 6; i++) begin
      present(1, 1, 0, 0);
      #1;
      if (i < 2) begin
        checks++;
        if (filling !== 1'b1 || ovalid !== 1'b0 || odata !== '0) begin
          errors++; $display("FAIL rstmid_fill i=%0d got f=%b v=%b d=%h", i, filling, ovalid, odata);
        end
      end else begin
        checks++;
        if (filling !== 1'b0 || ovalid !== 1'b1 || odata !== mk(seq - 2)) begin
          errors++; $display("FAIL rstmid_run i=%0d got v=%b d=%h exp d=%h", i, ovalid, odata, mk(seq - 2));
        end
      end
      advance();
    end
  endtask

  task automatic test_load_at_fill_end();
    present(1, 1, 1, 4'd2);
    #1;
    checks++;
    if (ovalid !== 1'b1 || odata !== mk(seq - 2)) begin
      errors++; $display("FAIL ldend_load_cycle got v=%b d=%h exp d=%h", ovalid, odata, mk(seq - 2));
    end
    advance();
    present(1, 1, 0, 0);
    #1;
    checks++;
    if (filling !== 1'b1) begin errors++; $display("FAIL ldend_fill0 got f=%b exp=1", filling); end
    advance();
    present(1, 1, 1, 4'd2);
    #1;
    checks++;
    if (filling !== 1'b1) begin errors++; $display("FAIL ldend_fill1 got f=%b exp=1", filling); end
    advance();
    for (int i = 0; i < 6; i++) begin
      present(1, 1, 0, 0);
      #1;
      if (i < 2) begin
        checks++;
        if (filling !== 1'b1 || ovalid !== 1'b0) begin
          errors++; $display("FAIL ldend_refill i=%0d got f=%b v=%b", i, filling, ovalid);
        end
      end else begin
        checks++;
        if (filling !== 1'b0 || ovalid !== 1'b1 || odata !== mk(seq - 2)) begin
          errors++; $display("FAIL ldend_run i=%0d got v=%b d=%h exp d=%h", i, ovalid, odata, mk(seq - 2));
        end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_fill_default();
    test_stall();
    test_max_delay(4'd8, 2);
    test_max_delay(4'd12, 8);
    test_valid_gaps();
    test_bypass();
    test_fill_restart();
    test_reset_mid();
    test_load_at_fill_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the whole run is a few hundred cycles.
  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog timeout at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_buffer_2d_var.md
Name: delay_buffer_2d_var

Overview:
- Runtime-programmable delay line for a 2D feature/element array (NUM_FEATURES x N words of PRECISION bits), with valid tracking and clock-enable stall.
- Successor to the fixed-DELAY 2D delay buffer: adds async reset, ce stall, per-sample valid, and a runtime delay select up to MAX_DELAY.
- Outputs are suppressed until the line is refilled after reset or a delay reload.
- Sits between feature-extraction stages to align parallel datapaths whose latency is configured at runtime.

Parameters:
- NUM_FEATURES, 4, outer array dimension.
- N, 4, inner array dimension.
- PRECISION, 4, bits per element.
- MAX_DELAY, 8, ring depth and maximum programmable delay; must be >= 1.
- DEFAULT_DELAY, 2, delay in effect after reset; must be <= MAX_DELAY.
- DW, $clog2(MAX_DELAY+1), derived localparam; width of delay_sel.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  advance enable; ring write, pointer move and fill count occur only when ce=1.
- delay_ld  in  1  load strobe for delay_sel.
- delay_sel  in  DW  requested delay in ce-advances; values > MAX_DELAY clamp to MAX_DELAY.
- ivalid  in  1  input sample valid; stored alongside data.
- idata  in  [PRECISION-1:0] x [NUM_FEATURES-1:0][N-1:0]  input array.
- ovalid  out  1  output sample valid.
- odata  out  [PRECISION-1:0] x [NUM_FEATURES-1:0][N-1:0]  delayed array.
- filling  out  1  high while state is FILL.

Behaviour:
- Storage: ring of MAX_DELAY entries, each holding the data array plus one valid bit. wptr points to the next slot to write.
- Write: on ce=1, mem[wptr] <= {ivalid, idata}; wptr <= (wptr == MAX_DELAY-1) ? 0 : wptr+1.
- Read: combinational from slot (wptr - cur_delay) mod MAX_DELAY.
  - cur_delay == MAX_DELAY reads slot wptr, the oldest entry, before it is overwritten.
- cur_delay == 0 is a bypass: odata = idata, ovalid = ivalid & (state == RUN).
- Latency: with ce held at 1, the sample presented before edge k appears on odata after edge k+cur_delay-1, so it is observable for exactly cur_delay edges of delay. ce=0 cycles do not count toward the delay.
- FSM states: FILL, RUN.
  - Reset: cur_delay=DEFAULT_DELAY, wptr=0, fill_cnt=0, ring valid bits=0, state = (DEFAULT_DELAY == 0) ? RUN : FILL.
  - FILL: on ce=1, fill_cnt++. When fill_cnt+1 == cur_delay, go to RUN.
  - RUN: hold state until delay_ld.
  - delay_ld (any state, ce ignored): cur_delay <= clamp(delay_sel), fill_cnt <= 0, state <= (clamped == 0) ? RUN : FILL. The old configuration drives outputs during the load cycle.
  - delay_ld during FILL restarts the fill with the new value.
  - delay_ld coinciding with the FILL->RUN edge: the load wins.
- Outputs:
  - In RUN: odata = read data, ovalid = stored valid.
  - In FILL: odata = 0, ovalid = 0, filling = 1.
- Reset asserted mid-operation: all state returns to reset values immediately. Ring data contents are don't-care because only valid bits are cleared.
- ce=0: outputs remain stable except in bypass mode, where they follow idata.

Optional Feature:
- Macro: DELAY_BUFFER_OUTPUT_REG_EN.
- Defined: odata, ovalid and filling are registered; the register updates every clock regardless of ce. This adds exactly 1 clk of latency on top of the ce-based delay. The registered outputs reset to 0 (filling resets to 1 if the reset state is FILL).
- Undefined: outputs are combinational as described in Behaviour.

Decomposition:
- Package delay_buffer_pkg:
  - state enum {FILL, RUN};
  - function clamp_delay(sel, max).
- Sub-module delay_ring_2d: the ring memory, wptr and read-index arithmetic. Top level keeps the FSM, cur_delay, fill_cnt and output muxing.

Test Plan:
- Reset then RUN at DEFAULT_DELAY=2, ce=1, feed rows {1,2,3,4}..{4,5,6,7} one per cycle with ivalid=1 -> ovalid=0 and filling=1 for 2 cycles; then odata = {1,2,3,4} on the 3rd cycle, {2,3,4,5} on the 4th.
- Stall: ce=0 for 3 cycles mid-stream -> odata and ovalid hold; after ce returns to 1, the sequence continues with no sample lost or duplicated.
- Reload delay_sel=8 (MAX) -> 8 FILL cycles; the wrap at wptr 7->0 delivers the sample pushed 8 advances earlier. Reload delay_sel=12 -> clamps to 8, same result.
- Reload delay_sel=0 -> next cycle RUN with bypass: odata == idata combinationally, ovalid == ivalid. ivalid=0 gaps propagate as ovalid=0 at the correct delay for delay 3.
- delay_ld pulsed again 1 cycle into FILL (3 then 5) -> the fill restarts; RUN is entered after 5 ce advances.
- rst_n pulsed low mid-stream -> outputs drop asynchronously (ovalid=0, odata=0). After release: FILL at DEFAULT_DELAY. Repeat with DELAY_BUFFER_OUTPUT_REG_EN defined -> every response is shifted by 1 clk.
